// File: rtl/param_register_file.sv
// Multi-port register file with a per-register busy scoreboard.
// Writes and reservations commit on the rising edge; read data is captured on
// the falling edge, so a value written at a rising edge is readable within the
// same cycle without a bypass path.
module param_register_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rdAddr,
  output logic [NUM_RD*DATA_W-1:0]   rdData,
  output logic [NUM_RD-1:0]          rdBusy,
  input  logic [NUM_WR-1:0]          wrEn,
  input  logic [NUM_WR*ADDR_W-1:0]   wrAddr,
  input  logic [NUM_WR*DATA_W-1:0]   wrData,
  input  logic                       rsvEn,
  input  logic [ADDR_W-1:0]          rsvAddr
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  // Register 0 never changes when it is hardwired to zero.
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Ports are applied in ascending order so the highest-indexed port wins a
  // conflict; the reservation is applied last so a new producer keeps busy set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wrEn[w] && writable(wrAddr[w*ADDR_W +: ADDR_W])) begin
          mem[wrAddr[w*ADDR_W +: ADDR_W]]  <= wrData[w*DATA_W +: DATA_W];
          busy[wrAddr[w*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      if (rsvEn && writable(rsvAddr)) begin
        busy[rsvAddr] <= 1'b1;
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      rdData <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_RD; p++) begin
        rdData[p*DATA_W +: DATA_W] <= mem[rdAddr[p*ADDR_W +: ADDR_W]];
      end
    end
  end

  always_comb begin
    rdBusy = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rdBusy[p] = busy[rdAddr[p*ADDR_W +: ADDR_W]];
    end
  end

endmodule
